// File: rtl/vending_machine_def.sv
// Shared vending machine definitions: coin table, widths, idle wait time.
// Also holds the helper that maps a one-hot coin select to its value.
package vending_machine_def;

    localparam int kNumCoins  = 3;
    localparam int kTotalBits = 31;
    localparam int kWaitTime  = 10;

    localparam logic [kTotalBits-1:0] kCoinValue [kNumCoins] = '{
        31'd100,
        31'd500,
        31'd1000
    };

    function automatic logic [kTotalBits-1:0] coin_value(
        input logic [kNumCoins-1:0] sel
    );
        logic [kTotalBits-1:0] v;
        v = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            if (sel[k]) v = v | kCoinValue[k];
        end
        return v;
    endfunction

endpackage

// File: rtl/coin_picker.sv
// Combinational selector: largest stocked coin not exceeding the remainder.
module coin_picker
    import vending_machine_def::*;
(
    input  logic [kTotalBits-1:0] i_remaining,
    input  logic [kNumCoins-1:0]  i_avail,
    output logic                  o_found,
    output logic [kNumCoins-1:0]  o_sel
);

    // Ascending scan: the last match is the highest denomination.
    always_comb begin
        o_found = 1'b0;
        o_sel   = '0;
        for (int k = 0; k < kNumCoins; k++) begin
            if (i_avail[k] && (kCoinValue[k] <= i_remaining)) begin
                o_found  = 1'b1;
                o_sel    = '0;
                o_sel[k] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/change_return_sequencer.sv
// Change return sequencer: pays out the balance one coin at a time.
// Define RETURN_TIMEOUT_EN to also start a return when the idle timer expires.
module change_return_sequencer
    import vending_machine_def::*;
(
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  i_input_event,
    input  logic                  i_trigger_return,
    input  logic [kTotalBits-1:0] i_current_total,
    input  logic [kNumCoins-1:0]  i_coin_avail,
    input  logic                  i_coin_ready,
    output logic                  o_coin_valid,
    output logic [kNumCoins-1:0]  o_coin_sel,
    output logic [kTotalBits-1:0] o_total_dec,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [kTotalBits-1:0] o_residual,
    output logic [31:0]           o_wait_time
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SELECT,
        S_ISSUE,
        S_DONE
    } state_t;

    state_t                r_state;
    logic [kTotalBits-1:0] r_remaining;
    logic [31:0]           r_timer;

    logic                  w_found;
    logic [kNumCoins-1:0]  w_sel;
    logic                  w_start;

    coin_picker u_picker (
        .i_remaining (r_remaining),
        .i_avail     (i_coin_avail),
        .o_found     (w_found),
        .o_sel       (w_sel)
    );

`ifdef RETURN_TIMEOUT_EN
    assign w_start = i_trigger_return ||
                     ((r_timer == 32'd0) && (i_current_total != '0));
`else
    assign w_start = i_trigger_return;
`endif

    assign o_wait_time = r_timer;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_remaining  <= '0;
            r_timer      <= 32'(kWaitTime);
            o_coin_valid <= 1'b0;
            o_coin_sel   <= '0;
            o_total_dec  <= '0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_residual   <= '0;
        end else begin
            o_total_dec <= '0;
            o_done      <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (i_input_event || (i_current_total == '0)) begin
                        r_timer <= 32'(kWaitTime);
                    end else if (r_timer != 32'd0) begin
                        r_timer <= r_timer - 32'd1;
                    end
                    if (w_start) begin
                        r_remaining <= i_current_total;
                        o_busy      <= 1'b1;
                        r_state     <= S_SELECT;
                    end
                end
                S_SELECT: begin
                    if (w_found) begin
                        o_coin_valid <= 1'b1;
                        o_coin_sel   <= w_sel;
                        r_state      <= S_ISSUE;
                    end else begin
                        o_done     <= 1'b1;
                        o_residual <= r_remaining;
                        r_state    <= S_DONE;
                    end
                end
                S_ISSUE: begin
                    // Picker guarantees the coin fits, so no underflow here.
                    if (i_coin_ready) begin
                        r_remaining  <= r_remaining - coin_value(o_coin_sel);
                        o_total_dec  <= coin_value(o_coin_sel);
                        o_coin_valid <= 1'b0;
                        o_coin_sel   <= '0;
                        r_state      <= S_SELECT;
                    end
                end
                S_DONE: begin
                    r_timer <= 32'(kWaitTime);
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_change_return_sequencer.sv
// Randomized self-checking bench for change_return_sequencer.
// Greedy payout model built from plain arithmetic on the coin table.
`timescale 1ns/1ps
module tb_change_return_sequencer;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        i_input_event;
    logic        i_trigger_return;
    logic [30:0] i_current_total;
    logic [2:0]  i_coin_avail;
    logic        i_coin_ready;
    logic        o_coin_valid;
    logic [2:0]  o_coin_sel;
    logic [30:0] o_total_dec;
    logic        o_busy;
    logic        o_done;
    logic [30:0] o_residual;
    logic [31:0] o_wait_time;

    int total_cnt = 0;
    int bad_cnt   = 0;
    int cval [3]  = '{100, 500, 1000};
    int exp_q [$];
    int exp_res;

    always #5 clk = ~clk;

    change_return_sequencer dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .i_input_event    (i_input_event),
        .i_trigger_return (i_trigger_return),
        .i_current_total  (i_current_total),
        .i_coin_avail     (i_coin_avail),
        .i_coin_ready     (i_coin_ready),
        .o_coin_valid     (o_coin_valid),
        .o_coin_sel       (o_coin_sel),
        .o_total_dec      (o_total_dec),
        .o_busy           (o_busy),
        .o_done           (o_done),
        .o_residual       (o_residual),
        .o_wait_time      (o_wait_time)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        total_cnt++;
        if (got !== exp) begin
            bad_cnt++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic build_model(input int total, input logic [2:0] avail);
        int rem;
        rem = total;
        exp_q.delete();
        for (int k = 2; k >= 0; k--) begin
            if (avail[k]) begin
                while (rem >= cval[k]) begin
                    exp_q.push_back(k);
                    rem -= cval[k];
                end
            end
        end
        exp_res = rem;
    endtask

    // mode 0: ready always 1, 1: random ready + noise, 2: hold ready low 5 cycles
    task automatic run_return(input string name, input int total,
                              input logic [2:0] avail, input int mode);
        int dec_sum = 0;
        int dones   = 0;
        int hold    = 0;
        int cyc     = 0;
        int exp_dec = 0;
        int k;
        logic       prev_wait = 1'b0;
        logic [2:0] prev_sel  = 3'b000;
        logic [2:0] oh;
        build_model(total, avail);
        @(negedge clk);
        i_current_total  = 31'(total);
        i_coin_avail     = avail;
        i_trigger_return = 1'b1;
        i_input_event    = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        i_trigger_return = 1'b0;
        i_input_event    = 1'b0;
        check({name, " busy"}, o_busy, 1);
        while (dones == 0 && cyc < 600) begin
            check({name, " dec"}, o_total_dec, exp_dec);
            dec_sum += int'(o_total_dec);
            if (prev_wait) begin
                check({name, " hold valid"}, o_coin_valid, 1);
                check({name, " hold sel"}, o_coin_sel, prev_sel);
            end
            if (!o_coin_valid) check({name, " idle sel"}, o_coin_sel, 0);
            if (o_done) begin
                dones++;
                check({name, " residual"}, o_residual, exp_res);
                check({name, " dec sum"}, dec_sum, total - exp_res);
                check({name, " coins left"}, exp_q.size(), 0);
            end
            case (mode)
                0: i_coin_ready = 1'b1;
                1: i_coin_ready = 1'($urandom_range(0, 1));
                default: begin
                    if (o_coin_valid && hold < 5) begin
                        i_coin_ready = 1'b0;
                        hold++;
                    end else begin
                        i_coin_ready = 1'b1;
                    end
                end
            endcase
            if (mode == 1 && !o_done) begin
                i_trigger_return = 1'($urandom_range(0, 1));
                i_input_event    = 1'($urandom_range(0, 1));
            end else begin
                i_trigger_return = 1'b0;
                i_input_event    = 1'b0;
            end
            exp_dec   = 0;
            prev_wait = 1'b0;
            if (o_coin_valid) begin
                if (i_coin_ready) begin
                    if (exp_q.size() == 0) begin
                        check({name, " extra coin"}, o_coin_sel, 0);
                    end else begin
                        k  = exp_q.pop_front();
                        oh = 3'b001 << k;
                        check({name, " coin"}, o_coin_sel, oh);
                        exp_dec = cval[k];
                    end
                end else begin
                    prev_wait = 1'b1;
                    prev_sel  = o_coin_sel;
                end
            end
            @(negedge clk);
            cyc++;
        end
        i_trigger_return = 1'b0;
        i_input_event    = 1'b0;
        if (dones == 0) check({name, " timeout"}, 0, 1);
        check({name, " done once"}, o_done, 0);
        check({name, " busy end"}, o_busy, 0);
        check({name, " residual hold"}, o_residual, exp_res);
        if (mode == 2) check({name, " held cycles"}, hold, 5);
    endtask

    task automatic reset_mid_issue();
        int cyc = 0;
        @(negedge clk);
        i_current_total  = 31'd1600;
        i_coin_avail     = 3'b111;
        i_coin_ready     = 1'b0;
        i_trigger_return = 1'b1;
        @(negedge clk);
        i_trigger_return = 1'b0;
        while (!o_coin_valid && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("rst in issue", o_coin_valid, 1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst valid", o_coin_valid, 0);
        check("rst sel", o_coin_sel, 0);
        check("rst busy", o_busy, 0);
        check("rst wait", o_wait_time, 10);
        check("rst residual", o_residual, 0);
        check("rst dec", o_total_dec, 0);
        reset_n         = 1'b1;
        i_coin_ready    = 1'b1;
        i_current_total = '0;
        @(negedge clk);
        check("rst idle", o_busy, 0);
    endtask

    task automatic timer_test();
        int  exp_t   = 10;
        bit  go      = 1'b0;
        int  start_c = -1;
        int  cyc     = 0;
        @(negedge clk);
        i_current_total = 31'd500;
        i_coin_avail    = 3'b111;
        i_coin_ready    = 1'b1;
        i_input_event   = 1'b1;
        @(negedge clk);
        for (int c = 1; c <= 30 && start_c < 0; c++) begin
            if (go) begin
                check("tmr start busy", o_busy, 1);
                start_c = c;
            end else begin
                check("tmr value", o_wait_time, exp_t);
                check("tmr idle", o_busy, 0);
                i_input_event = (c == 6);
`ifdef RETURN_TIMEOUT_EN
                go = (exp_t == 0);
`endif
                if (i_input_event) exp_t = 10;
                else if (exp_t > 0) exp_t = exp_t - 1;
                @(negedge clk);
            end
        end
        i_input_event = 1'b0;
`ifdef RETURN_TIMEOUT_EN
        check("tmr start cycle", start_c, 18);
        while (!o_done && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("tmr return done", o_done, 1);
`else
        check("tmr no start", start_c, -1);
`endif
        i_current_total = '0;
        @(negedge clk);
    endtask

    initial begin
        reset_n          = 1'b0;
        i_input_event    = 1'b0;
        i_trigger_return = 1'b0;
        i_current_total  = '0;
        i_coin_avail     = 3'b111;
        i_coin_ready     = 1'b1;
        repeat (2) @(negedge clk);
        check("reset valid", o_coin_valid, 0);
        check("reset sel", o_coin_sel, 0);
        check("reset dec", o_total_dec, 0);
        check("reset busy", o_busy, 0);
        check("reset done", o_done, 0);
        check("reset residual", o_residual, 0);
        check("reset wait", o_wait_time, 10);
        reset_n = 1'b1;
        @(negedge clk);

        run_return("t1600", 1600, 3'b111, 0);
        run_return("t1100", 1100, 3'b011, 0);
        run_return("t250", 250, 3'b111, 0);
        run_return("t0", 0, 3'b111, 0);
        run_return("thold", 600, 3'b111, 2);
        reset_mid_issue();
        for (int i = 0; i < 8; i++) begin
            run_return("rand", int'($urandom_range(0, 4000)),
                       3'($urandom_range(0, 7)), 1);
        end
        timer_test();

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule

// File: doc/change_return_sequencer.md
CHANGE_RETURN_SEQUENCER -- requirements
Module: change_return_sequencer

Interface
REQ-001 SHALL have ports: clk, input, 1, system clock, all state changes on rising edge.
REQ-002 SHALL have ports: reset_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have ports: i_input_event, input, 1, coin inserted or item dispensed this cycle.
REQ-004 SHALL have ports: i_trigger_return, input, 1, user return-button request.
REQ-005 SHALL have ports: i_current_total, input, kTotalBits, balance held by the vending datapath.
REQ-006 SHALL have ports: i_coin_avail, input, kNumCoins, per-denomination hopper stock flag.
REQ-007 SHALL have ports: i_coin_ready, input, 1, hopper accepts the offered coin.
REQ-008 SHALL have ports: o_coin_valid, output, 1, coin offer valid.
REQ-009 SHALL have ports: o_coin_sel, output, kNumCoins, one-hot offered denomination.
REQ-010 SHALL have ports: o_total_dec, output, kTotalBits, amount to subtract from the balance, valid one cycle.
REQ-011 SHALL have ports: o_busy, output, 1, return in progress; upstream blocks inputs.
REQ-012 SHALL have ports: o_done, output, 1, one-cycle pulse at end of return.
REQ-013 SHALL have ports: o_residual, output, kTotalBits, balance not payable at last return.
REQ-014 SHALL have ports: o_wait_time, output, 32, idle countdown value.

Function
REQ-015 SHALL implement FSM S_IDLE, S_SELECT, S_ISSUE, S_DONE.
REQ-016 S_IDLE: timer SHALL reload to kWaitTime on i_input_event or when i_current_total==0, else decrement by 1 per cycle, saturating at 0.
REQ-017 S_IDLE: i_trigger_return SHALL latch remaining=i_current_total and go to S_SELECT next cycle, even if the total is 0.
REQ-018 S_SELECT SHALL pick the highest index k with coin_value[k]<=remaining and i_coin_avail[k]=1; if found go S_ISSUE, else go S_DONE (one cycle per decision).
REQ-019 S_ISSUE SHALL assert o_coin_valid with o_coin_sel held stable until the cycle where i_coin_ready=1.
REQ-020 On the handshake, the block SHALL set remaining -= coin_value[k], pulse o_total_dec=coin_value[k] in the following cycle, and return to S_SELECT.
REQ-021 o_total_dec SHALL be 0 in all other cycles, and o_coin_sel SHALL be 0 when o_coin_valid=0.
REQ-022 S_DONE SHALL pulse o_done, load o_residual=remaining, reload the timer, and go to S_IDLE.
REQ-023 o_busy SHALL be 1 in S_SELECT, S_ISSUE, and S_DONE.
REQ-024 i_trigger_return and i_input_event SHALL be ignored while o_busy=1.
REQ-025 Arithmetic SHALL be unsigned kTotalBits; remaining SHALL never underflow.
REQ-026 Simultaneous i_trigger_return and i_input_event in S_IDLE: return SHALL win.

Reset
REQ-027 reset_n=0 at a clock edge SHALL force S_IDLE, timer=kWaitTime, remaining=0, o_residual=0, and every other output 0, including mid-handshake.

Configuration
REQ-028 With RETURN_TIMEOUT_EN defined, S_IDLE SHALL also start a return (as REQ-017) when timer==0 and i_current_total!=0.
REQ-029 Without RETURN_TIMEOUT_EN, only i_trigger_return SHALL start a return; the timer SHALL still count and be visible on o_wait_time.

Structure
REQ-030 kNumCoins=3, kTotalBits=31, kWaitTime=10, and coin values {100,500,1000} SHALL live in the shared vending_machine_def header.
REQ-031 State encoding SHALL be local to the block.
REQ-032 The largest-coin selector SHALL be a combinational sub-module named coin_picker.

Verification
REQ-033 Bench SHALL cover: total=1600, all avail, ready always 1, trigger -> coins 1000, 500, 100 in order, o_total_dec sums to 1600, o_residual=0, o_done pulses once.
REQ-034 Bench SHALL cover: total=1100, avail=3'b011 (no 1000) -> 500, 500, 100, o_residual=0.
REQ-035 Bench SHALL cover: total=250, all avail -> 100, 100, o_residual=50.
REQ-036 Bench SHALL cover: ready held 0 for 5 cycles in S_ISSUE -> o_coin_valid and o_coin_sel stable for the 5 cycles, then one coin is issued.
REQ-037 Bench SHALL cover: RETURN_TIMEOUT_EN defined, total=500, no events -> return starts 10 cycles after the last i_input_event; an event at cycle 6 restarts the count.
REQ-038 Bench SHALL cover: reset_n=0 during S_ISSUE -> next cycle S_IDLE, o_coin_valid=0, o_wait_time=10.
